// File: rtl/ram_stream_reader.sv
// ram_stream_reader: fetches a run of halfwords from a shared RAM
// client port into a small first-word fall-through output FIFO.
module ram_stream_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [17:0] cmd_adr,
  input  logic [9:0]  cmd_len,
  output logic        busy,
  output logic        done,
  output logic [17:0] m_adr,
  output logic        m_req,
  input  logic        m_ack,
  output logic        m_write,
  output logic [1:0]  m_sel,
  input  logic [15:0] m_rdata,
  output logic [15:0] m_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state;
  logic [9:0]    remaining;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // write side is a read-only client
  assign m_write = 1'b0;
  assign m_sel   = 2'b11;
  assign m_wdata = 16'h0000;

  // an ack only counts against an outstanding request, which
  // always owns a reserved slot, so push never overflows
  assign push      = m_req & m_ack;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // command sequencing and RAM request handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      m_adr     <= '0;
      m_req     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            m_adr     <= cmd_adr;
            remaining <= cmd_len;
            busy      <= 1'b1;
            if (cmd_len == 10'd0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (m_req) begin
            if (m_ack) begin
              m_adr     <= m_adr + 18'd1;
              remaining <= remaining - 10'd1;
              if (remaining == 10'd1) begin
                m_req <= 1'b0;
                state <= S_FINISH;
                done  <= 1'b1;
              end else begin
                m_req <= (count_nxt < FULL);
              end
            end
          end else if (remaining != 10'd0 && count < FULL) begin
            m_req <= 1'b1;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          m_req <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_rdata;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed scenarios against a one-cycle
// latency arbiter model returning rdata = adr ^ 0xA5A5.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [17:0] cmd_adr = '0;
  logic [9:0]  cmd_len = '0;
  logic        busy;
  logic        done;
  logic [17:0] m_adr;
  logic        m_req;
  logic        m_ack = 1'b0;
  logic        m_write;
  logic [1:0]  m_sel;
  logic [15:0] m_rdata;
  logic [15:0] m_wdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic arb_en = 1'b0;

  logic [17:0] ack_adr[$];
  int          ack_cyc[$];
  logic [15:0] outs[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int req_cnt = 0;
  int ov_cnt = 0;

  ram_stream_reader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .m_adr(m_adr), .m_req(m_req), .m_ack(m_ack),
    .m_write(m_write), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_wdata(m_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // arbiter: grants one cycle after seeing a request, and
  // ignores the request during its own ack cycle
  always @(posedge clk) m_ack <= arb_en && m_req && !m_ack;

  assign m_rdata = m_ack ? (m_adr[15:0] ^ 16'hA5A5) : 16'h0000;

  // passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (m_req === 1'b1 && m_ack === 1'b1) begin
      ack_adr.push_back(m_adr);
      ack_cyc.push_back(cyc);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1)
      outs.push_back(out_data);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_req === 1'b1) req_cnt++;
    if (out_valid === 1'b1) ov_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    ack_adr.delete();
    ack_cyc.delete();
    outs.delete();
    done_cnt = 0;
    done_cyc = 0;
    req_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic start_cmd(input logic [17:0] a,
                           input logic [9:0] l,
                           output int c);
    @(posedge clk) #1;
    cmd_adr = a;
    cmd_len = l;
    cmd_start = 1'b1;
    @(posedge clk) #1;
    c = cyc;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk) #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b busy=%b done=%b want 0 0 0",
               m_req, busy, done);
    end
    checks++;
    if (out_valid !== 1'b0 || m_adr !== 18'h0) begin
      failures++;
      $display("FAIL reset_fifo valid=%b adr=%h want 0 00000",
               out_valid, m_adr);
    end
    checks++;
    if (m_write !== 1'b0 || m_sel !== 2'b11 || m_wdata !== 16'h0) begin
      failures++;
      $display("FAIL tie_offs we=%b sel=%b wd=%h want 0 11 0000",
               m_write, m_sel, m_wdata);
    end
    rst = 1'b0;
    arb_en = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_basic();
    int c;
    bit ok;
    logic [15:0] exp [3];
    exp[0] = 16'hA5B5;
    exp[1] = 16'hA5B4;
    exp[2] = 16'hA5B7;
    out_ready = 1'b1;
    clear_mon();
    start_cmd(18'h00010, 10'd3, c);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b want=1", busy);
    end
    wait_done(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_done_timeout got=0 want=1");
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_adr.size() != 3) begin
      failures++;
      $display("FAIL basic_ack_count got=%0d want=3", ack_adr.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ack_adr.size() || ack_adr[i] !== 18'h10 + 18'(i)) begin
        failures++;
        $display("FAIL basic_adr[%0d] want=%h", i, 18'h10 + 18'(i));
      end
      checks++;
      if (i >= outs.size() || outs[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_data[%0d] got=%h want=%h", i,
                 (i < outs.size()) ? outs[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++;
    if (ack_cyc.size() != 3 || ack_cyc[0] - c != 2 ||
        ack_cyc[1] - ack_cyc[0] != 2 || ack_cyc[2] - ack_cyc[1] != 2) begin
      failures++;
      $display("FAIL basic_ack_spacing acks=%0d want 3 at +2,+4,+6",
               ack_cyc.size());
    end
    checks++;
    if (done_cyc - c != 7) begin
      failures++;
      $display("FAIL basic_done_time got=+%0d want=+7", done_cyc - c);
    end
    checks++;
    if (req_cnt != 6) begin
      failures++;
      $display("FAIL basic_req_cycles got=%0d want=6", req_cnt);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got=%0d busy=%b want 1 0",
               done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int c;
    bit ok;
    out_ready = 1'b0;
    clear_mon();
    start_cmd(18'h00100, 10'd8, c);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (ack_adr.size() != 4) begin
      failures++;
      $display("FAIL bp_stall_acks got=%0d want=4", ack_adr.size());
    end
    checks++;
    if (m_req !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall_state req=%b valid=%b busy=%b want 0 1 1",
               m_req, out_valid, busy);
    end
    checks++;
    if (out_data !== 16'hA4A5) begin
      failures++;
      $display("FAIL bp_head got=%h want=a4a5", out_data);
    end
    out_ready = 1'b1;
    wait_done(80, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_done_timeout got=0 want=1");
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (outs.size() != 8 || ack_adr.size() != 8) begin
      failures++;
      $display("FAIL bp_count words=%0d acks=%0d want 8 8",
               outs.size(), ack_adr.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (16'h0100 + 16'(i)) ^ 16'hA5A5;
      checks++;
      if (i >= outs.size() || outs[i] !== e) begin
        failures++;
        $display("FAIL bp_data[%0d] got=%h want=%h", i,
                 (i < outs.size()) ? outs[i] : 16'hxxxx, e);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%b want=0", out_valid);
    end
  endtask

  task automatic test_zero_len();
    int c;
    out_ready = 1'b1;
    clear_mon();
    start_cmd(18'h00055, 10'd0, c);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || done_cyc != c) begin
      failures++;
      $display("FAIL zero_done cnt=%0d at=+%0d want 1 +0",
               done_cnt, done_cyc - c);
    end
    checks++;
    if (req_cnt != 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL zero_activity req=%0d valid=%0d want 0 0",
               req_cnt, ov_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_wrap();
    int c;
    bit ok;
    out_ready = 1'b1;
    clear_mon();
    start_cmd(18'h3FFFF, 10'd2, c);
    wait_done(40, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || ack_adr.size() != 2) begin
      failures++;
      $display("FAIL wrap_acks got=%0d want=2", ack_adr.size());
    end
    checks++;
    if (ack_adr.size() < 2 || ack_adr[0] !== 18'h3FFFF ||
        ack_adr[1] !== 18'h00000) begin
      failures++;
      $display("FAIL wrap_adr want 3ffff then 00000");
    end
    checks++;
    if (outs.size() != 2 || outs[0] !== 16'h5A5A ||
        outs[1] !== 16'hA5A5) begin
      failures++;
      $display("FAIL wrap_data words=%0d want 5a5a a5a5", outs.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bit ok;
    out_ready = 1'b0;
    clear_mon();
    start_cmd(18'h00200, 10'd8, c);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk) #1;
      if (ack_adr.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || m_req !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre req=%b valid=%b want 1 1", m_req, out_valid);
    end
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    checks++;
    if (m_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid req=%b valid=%b busy=%b want 0 0 0",
               m_req, out_valid, busy);
    end
    checks++;
    if (m_adr !== 18'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_adr adr=%h done=%b want 00000 0",
               m_adr, done);
    end
    @(posedge clk) #1;
    checks++;
    if (out_valid !== 1'b0 || m_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_stray_ack valid=%b req=%b busy=%b want 0 0 0",
               out_valid, m_req, busy);
    end
    out_ready = 1'b1;
    clear_mon();
    start_cmd(18'h00007, 10'd1, c);
    wait_done(40, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || outs.size() != 1 || outs[0] !== 16'hA5A2) begin
      failures++;
      $display("FAIL rst_recover words=%0d want 1 word a5a2",
               outs.size());
    end
  endtask

  task automatic test_cmd_while_busy();
    int c;
    int c2;
    bit ok;
    out_ready = 1'b1;
    clear_mon();
    start_cmd(18'h00020, 10'd4, c);
    repeat (2) @(posedge clk);
    start_cmd(18'h00300, 10'd9, c2);
    wait_done(40, ok);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (!ok || ack_adr.size() != 4 || outs.size() != 4) begin
      failures++;
      $display("FAIL busy_cmd_count acks=%0d words=%0d want 4 4",
               ack_adr.size(), outs.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = (16'h0020 + 16'(i)) ^ 16'hA5A5;
      checks++;
      if (i >= ack_adr.size() || ack_adr[i] !== 18'h20 + 18'(i) ||
          i >= outs.size() || outs[i] !== e) begin
        failures++;
        $display("FAIL busy_cmd_word[%0d] want adr=%h data=%h",
                 i, 18'h20 + 18'(i), e);
      end
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL busy_cmd_end done=%0d busy=%b req=%b want 1 0 0",
               done_cnt, busy, m_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_cmd_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in 16-bit words (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, sole clock, all logic on posedge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd_start, input, 1, one-cycle command strobe.
REQ-005 SHALL have port cmd_adr, input, 18, first halfword address.
REQ-006 SHALL have port cmd_len, input, 10, halfword count (0..1023).
REQ-007 SHALL have port busy, output, 1, high while a command is active.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at command completion.
REQ-009 SHALL have port m_adr, output, 18, RAM client address.
REQ-010 SHALL have port m_req, output, 1, RAM client request.
REQ-011 SHALL have port m_ack, input, 1, RAM arbiter grant pulse.
REQ-012 SHALL have port m_write, output, 1, tied 0.
REQ-013 SHALL have port m_sel, output, 2, tied 2'b11.
REQ-014 SHALL have port m_rdata, input, 16, read data, valid in the cycle m_ack is high.
REQ-015 SHALL have port m_wdata, output, 16, tied 0.
REQ-016 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-018 SHALL have port out_data, output, 16, FIFO head word (first-word fall-through).

Function
REQ-019 SHALL implement states IDLE, ISSUE, FINISH.
REQ-020 IDLE: cmd_start latches adr and remaining=cmd_len, busy<=1; len!=0 -> ISSUE, len==0 -> FINISH with no request.
REQ-021 cmd_start SHALL be ignored outside IDLE.
REQ-022 m_req high reserves one FIFO slot; m_req SHALL rise only when FIFO count < FIFO_DEPTH.
REQ-023 m_req, m_adr SHALL stay stable until m_ack is sampled high.
REQ-024 On m_ack with m_req high: push m_rdata, remaining-1, adr+1 mod 2^18 (0x3FFFF wraps to 0x00000).
REQ-025 On that ack edge: remaining-1 > 0 and post-push/pop count < FIFO_DEPTH -> keep m_req high with new m_adr (arbiter ignores it during its ack cycle; throughput one word per 2 cycles); otherwise m_req<=0.
REQ-026 m_req low in ISSUE with remaining>0 SHALL re-assert as soon as count < FIFO_DEPTH.
REQ-027 Ack for the last word -> FINISH, m_req<=0.
REQ-028 FINISH: done=1 for exactly one cycle, busy<=0, -> IDLE; FIFO contents are kept and drained independently.
REQ-029 m_ack while m_req low SHALL be ignored (no push, no count change).
REQ-030 out_valid = count!=0; pop when out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-031 FIFO SHALL never overflow; pushes occur only into reserved slots.
REQ-032 Data SHALL leave in request-address order, no loss, no duplication.

Reset
REQ-033 rst SHALL force state IDLE, m_req=0, busy=0, done=0, m_adr=0, FIFO empty (out_valid=0), remaining=0 on the next edge, including mid-ISSUE.
REQ-034 An m_ack arriving the cycle after reset SHALL be ignored.

Verification
REQ-035 adr=0x00010, len=3, out_ready=1, arbiter model acks 1 cycle after req, rdata=adr^0xA5A5 -> out words 0xA5B5,0xA5B4,0xA5B7; req high continuously, acks 2 cycles apart; done 1 cycle after third ack.
REQ-036 len=8, out_ready=0 -> exactly 4 acks then m_req low, out_valid=1; raise out_ready -> remaining 4 words fetched, 8 words total in order.
REQ-037 len=0 -> done pulse one cycle after cmd_start, m_req never high, out_valid stays 0.
REQ-038 adr=0x3FFFF, len=2 -> m_adr sequence 0x3FFFF then 0x00000.
REQ-039 rst asserted while m_req high with 2 words buffered -> next cycle m_req=0, out_valid=0, busy=0; stray ack ignored.
REQ-040 cmd_start pulsed while busy -> ignored; word count and addresses of the active command unchanged.
